// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32 general registers plus HI/LO, two combinational
// read ports with same-cycle write bypass, and a counter of committing writeback cycles.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_whilo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [31:0]       retire_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [31:0]       cnt_q;

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_wreg && (wb_wd != '0)) begin
            regs[wb_wd] <= wb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_whilo) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
        end
    end

    // A discarded write to register 0 still retires an instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (wb_wreg || wb_whilo) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (!rst && re1 && (raddr1 != '0)) begin
            if (wb_wreg && (raddr1 == wb_wd)) begin
                rdata1 = wb_wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst && re2 && (raddr2 != '0)) begin
            if (wb_wreg && (raddr2 == wb_wd)) begin
                rdata2 = wb_wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: expected values are queued as stimulus is driven
// and popped when the corresponding output is sampled.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] exp_cnt;

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        @(negedge clk);
        rst = 1; wb_wreg = 1; wb_wd = 5; wb_wdata = 32'hDEADBEEF;
        re1 = 1; raddr1 = 5;
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back(32'h0);
            #1;
            exp = exp_q.pop_front(); checks++;
            if (rdata1 !== exp) begin errors++; $display("FAIL reset_rdata1: got %h expected %h", rdata1, exp); end
            @(negedge clk);
        end
        rst = 0; wb_wreg = 0;
        exp_cnt = 0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin errors++; $display("FAIL reset_r5: got %h expected %h", rdata1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (hi_o !== exp) begin errors++; $display("FAIL reset_hi: got %h expected %h", hi_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (lo_o !== exp) begin errors++; $display("FAIL reset_lo: got %h expected %h", lo_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (retire_cnt !== exp) begin errors++; $display("FAIL reset_cnt: got %h expected %h", retire_cnt, exp); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wb_wreg = 1; wb_wd = 7; wb_wdata = 32'h12345678; re1 = 1; raddr1 = 7;
        exp_q.push_back(32'h12345678);
        exp_cnt++;
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin errors++; $display("FAIL wr_bypass: got %h expected %h", rdata1, exp); end
        @(negedge clk);
        wb_wreg = 0; wb_wdata = 32'h0;
        exp_q.push_back(32'h12345678); exp_q.push_back(exp_cnt);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin errors++; $display("FAIL wr_storage: got %h expected %h", rdata1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (retire_cnt !== exp) begin errors++; $display("FAIL wr_cnt: got %h expected %h", retire_cnt, exp); end
        re1 = 0;
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin errors++; $display("FAIL wr_re_off: got %h expected %h", rdata1, exp); end
    endtask

    task automatic test_reg0();
        @(negedge clk);
        wb_wreg = 1; wb_wd = 0; wb_wdata = 32'hFFFFFFFF;
        re1 = 1; raddr1 = 0; re2 = 1; raddr2 = 0;
        exp_cnt++;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin errors++; $display("FAIL r0_p1_wcyc: got %h expected %h", rdata1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rdata2 !== exp) begin errors++; $display("FAIL r0_p2_wcyc: got %h expected %h", rdata2, exp); end
        @(negedge clk);
        wb_wreg = 0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(exp_cnt);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin errors++; $display("FAIL r0_p1_after: got %h expected %h", rdata1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rdata2 !== exp) begin errors++; $display("FAIL r0_p2_after: got %h expected %h", rdata2, exp); end
        exp = exp_q.pop_front(); checks++;
        if (retire_cnt !== exp) begin errors++; $display("FAIL r0_cnt: got %h expected %h", retire_cnt, exp); end
    endtask

    task automatic test_hilo();
        @(negedge clk);
        wb_whilo = 1; wb_hi = 32'hAAAA0000; wb_lo = 32'h0000BBBB;
        wb_wreg = 1; wb_wd = 3; wb_wdata = 32'h33;
        re1 = 0; re2 = 0;
        exp_cnt++;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (hi_o !== exp) begin errors++; $display("FAIL hilo_hi_before: got %h expected %h", hi_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (lo_o !== exp) begin errors++; $display("FAIL hilo_lo_before: got %h expected %h", lo_o, exp); end
        @(negedge clk);
        wb_whilo = 0; wb_wreg = 0; wb_hi = 32'h0; wb_lo = 32'h0;
        re1 = 1; raddr1 = 3;
        exp_q.push_back(32'hAAAA0000); exp_q.push_back(32'h0000BBBB);
        exp_q.push_back(32'h33); exp_q.push_back(exp_cnt);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (hi_o !== exp) begin errors++; $display("FAIL hilo_hi_after: got %h expected %h", hi_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (lo_o !== exp) begin errors++; $display("FAIL hilo_lo_after: got %h expected %h", lo_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin errors++; $display("FAIL hilo_r3: got %h expected %h", rdata1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (retire_cnt !== exp) begin errors++; $display("FAIL hilo_cnt: got %h expected %h", retire_cnt, exp); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wb_wreg = 1; wb_wd = 9; wb_wdata = 32'h11;
        @(negedge clk);
        wb_wd = 10; wb_wdata = 32'h55;
        @(negedge clk);
        wb_wd = 9; wb_wdata = 32'h22;
        re1 = 1; raddr1 = 9; re2 = 1; raddr2 = 9;
        exp_cnt += 3;
        exp_q.push_back(32'h22); exp_q.push_back(32'h22);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin errors++; $display("FAIL b2b_p1_bypass: got %h expected %h", rdata1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rdata2 !== exp) begin errors++; $display("FAIL b2b_p2_bypass: got %h expected %h", rdata2, exp); end
        raddr2 = 10;
        exp_q.push_back(32'h55); exp_q.push_back(32'h22);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rdata2 !== exp) begin errors++; $display("FAIL b2b_p2_r10: got %h expected %h", rdata2, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin errors++; $display("FAIL b2b_p1_hold: got %h expected %h", rdata1, exp); end
        @(negedge clk);
        wb_wreg = 0; raddr2 = 9;
        exp_q.push_back(32'h22); exp_q.push_back(32'h22); exp_q.push_back(exp_cnt);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin errors++; $display("FAIL b2b_p1_store: got %h expected %h", rdata1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rdata2 !== exp) begin errors++; $display("FAIL b2b_p2_store: got %h expected %h", rdata2, exp); end
        exp = exp_q.pop_front(); checks++;
        if (retire_cnt !== exp) begin errors++; $display("FAIL b2b_cnt: got %h expected %h", retire_cnt, exp); end
    endtask

    task automatic test_counter_reset();
        @(negedge clk);
        dut.cnt_q <= 32'hFFFFFFFE;
        wb_wreg = 1; wb_wd = 1; wb_wdata = 32'h1;
        @(negedge clk);
        wb_wreg = 0; wb_whilo = 1; wb_hi = 32'h5; wb_lo = 32'h6;
        exp_q.push_back(32'hFFFFFFFF);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (retire_cnt !== exp) begin errors++; $display("FAIL wrap_max: got %h expected %h", retire_cnt, exp); end
        @(negedge clk);
        wb_whilo = 0;
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (retire_cnt !== exp) begin errors++; $display("FAIL wrap_zero: got %h expected %h", retire_cnt, exp); end
        // commit a nonzero state so the reset below has something to clear
        @(negedge clk);
        wb_wreg = 1; wb_wd = 4; wb_wdata = 32'h44;
        @(negedge clk);
        rst = 1; wb_whilo = 1; wb_hi = 32'h12345; wb_lo = 32'h6789;
        wb_wd = 4; wb_wdata = 32'h99; re1 = 1; raddr1 = 4; re2 = 1; raddr2 = 7;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin errors++; $display("FAIL rst_mid_p1: got %h expected %h", rdata1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rdata2 !== exp) begin errors++; $display("FAIL rst_mid_p2: got %h expected %h", rdata2, exp); end
        @(negedge clk);
        rst = 0; wb_whilo = 0; wb_wreg = 0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (hi_o !== exp) begin errors++; $display("FAIL rst_mid_hi: got %h expected %h", hi_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (lo_o !== exp) begin errors++; $display("FAIL rst_mid_lo: got %h expected %h", lo_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (retire_cnt !== exp) begin errors++; $display("FAIL rst_mid_cnt: got %h expected %h", retire_cnt, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin errors++; $display("FAIL rst_mid_r4: got %h expected %h", rdata1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rdata2 !== exp) begin errors++; $display("FAIL rst_mid_r7: got %h expected %h", rdata2, exp); end
        wb_wreg = 1; wb_wd = 4; wb_wdata = 32'h77;
        exp_q.push_back(32'h77);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin errors++; $display("FAIL post_rst_bypass: got %h expected %h", rdata1, exp); end
        @(negedge clk);
        wb_wreg = 0;
        exp_q.push_back(32'h77); exp_q.push_back(32'h1);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rdata1 !== exp) begin errors++; $display("FAIL post_rst_store: got %h expected %h", rdata1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (retire_cnt !== exp) begin errors++; $display("FAIL post_rst_cnt: got %h expected %h", retire_cnt, exp); end
    endtask

    initial begin
        rst = 1; wb_wd = 0; wb_wreg = 0; wb_wdata = 0; wb_hi = 0; wb_lo = 0; wb_whilo = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        exp_cnt = 0;
        test_reset();
        test_write_read();
        test_reg0();
        test_hilo();
        test_back_to_back();
        test_counter_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side storage for the 5-stage pipeline: it consumes the MEM/WB register outputs and commits them into the 32×32 general register file and the HI/LO pair. It serves two combinational read ports for the decode stage, with same-cycle write-to-read bypass, and exposes the committed HI/LO values to execute. A retire counter records every writeback cycle that commits architectural state.

## Interface
Parameters:
- DATA_W, 32, register/HI/LO width
- ADDR_W, 5, register address width; file depth is 2**ADDR_W

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wb_wd  in  ADDR_W  destination register address from MEM/WB
- wb_wreg  in  1  general register write enable
- wb_wdata  in  DATA_W  general register write data
- wb_hi  in  DATA_W  HI write data
- wb_lo  in  DATA_W  LO write data
- wb_whilo  in  1  HI/LO write enable; writes both together
- re1  in  1  read port 1 enable
- raddr1  in  ADDR_W  read port 1 address
- rdata1  out  DATA_W  read port 1 data, combinational
- re2  in  1  read port 2 enable
- raddr2  in  ADDR_W  read port 2 address
- rdata2  out  DATA_W  read port 2 data, combinational
- hi_o  out  DATA_W  committed HI, registered
- lo_o  out  DATA_W  committed LO, registered
- retire_cnt  out  32  count of committing writeback cycles, registered

## Operation
- **Register write:** on a clock edge with rst=0, wb_wreg=1 and wb_wd≠0, store wb_wdata into reg[wb_wd].
  - Writes to register 0 are discarded; reg 0 always reads 0.
- **HI/LO write:** on a clock edge with rst=0 and wb_whilo=1, store HI←wb_hi and LO←wb_lo.
  - A general register write and a HI/LO write in the same cycle both commit.
- **Read port n (n=1,2):** priority, highest first:
  1. rst=1 → 0
  2. ren=0 → 0
  3. raddrn=0 → 0
  4. ren=1, wb_wreg=1 and raddrn=wb_wd → wb_wdata (bypass)
  5. otherwise → reg[raddrn]
- **Port independence:** the two ports are fully independent; both may read the same address, including the bypassed address.
- **hi_o/lo_o:** always the registered HI/LO. There is no bypass; HI/LO forwarding is done upstream in execute.
- **retire_cnt:** increments by 1 on each edge with rst=0 and (wb_wreg=1 or wb_whilo=1).
  - A write to reg 0 with wb_wreg=1 still counts.
  - Wraps 0xFFFFFFFF → 0.
- **Reset:** synchronous. On an edge with rst=1:
  - All general registers are cleared to 0.
  - HI, LO and retire_cnt are cleared to 0.
  - Any write presented in that cycle is suppressed.
- **Reset values:** rdata1/rdata2 = 0 while rst=1; hi_o = lo_o = 0 and retire_cnt = 0 after the reset edge.

## Timing
- **Write latency:** a register write is visible through storage from the cycle after the edge. In the write cycle itself it is visible through the bypass, so there is 0-cycle read-after-write on both ports.
- **HI/LO latency:** 1 cycle. hi_o/lo_o change on the edge that commits wb_whilo.
- **Read path:** fully combinational from raddr, ren, wb_wd, wb_wreg and wb_wdata to rdata. There is no clock dependency other than the stored value.
- **retire_cnt:** updates on the same edge as the commit it counts.
- **Reset mid-stream:** if rst is asserted while a write is presented, the write is lost and the state is zeroed. On the first cycle after rst deasserts, writes and reads behave normally.
- **Back-to-back writes to the same register:** the last edge wins. A read in the second write's cycle returns the second value via bypass.

## Test plan
- **Reset:** pulse rst for 2 cycles with wb_wreg=1, wb_wd=5, wb_wdata=0xDEADBEEF.
  - Expect rdata1 = 0 during reset.
  - After reset, read r5 → 0; hi_o = lo_o = 0; retire_cnt = 0.
- **Write then read:** write r7 = 0x12345678.
  - In the same cycle, re1=1, raddr1=7 → rdata1 = 0x12345678 (bypass).
  - Next cycle with wb_wreg=0, still 0x12345678 (storage).
  - re1=0 → rdata1 = 0.
- **Register 0 protection:** write r0 = 0xFFFFFFFF.
  - Both ports reading r0 → 0 in the write cycle and after.
  - retire_cnt increments by 1.
- **HI/LO:** wb_whilo=1, wb_hi=0xAAAA0000, wb_lo=0x0000BBBB, together with wb_wreg=1 writing r3 = 0x33.
  - hi_o/lo_o unchanged in that cycle and equal to the new values after the edge.
  - r3 = 0x33.
  - retire_cnt increments by exactly 1.
- **Dual-port bypass collision:** store r9 = 0x11, then write r9 = 0x22 with raddr1 = raddr2 = 9.
  - Both ports → 0x22.
  - With raddr2=10 (holding 0x55) → rdata2 = 0x55, unaffected.
- **Counter and reset interaction:** force 0xFFFFFFFE via 2³²−2 writes, or use a bench backdoor. Two commits wrap the counter to 0.
  - Assert rst in a cycle with wb_whilo=1 → HI stays 0 and retire_cnt = 0.
